// File: rtl/bar_steady_mon_mc.sv
// Per-channel bar stability monitor. A foo strobe captures bar, and bar must then
// hold for HOLD compare edges. The outcome is a steady level or a one-cycle violation pulse.
module bar_steady_mon_mc #(
    parameter  int CH   = 4,
    parameter  int W    = 8,
    parameter  int HOLD = 4,
    localparam int CW   = $clog2(HOLD + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH-1:0]   foo,
    input  logic [CH*W-1:0] bar,
    output logic [CH-1:0]   bar_steady,
    output logic [CH-1:0]   bar_viol,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD - 1);

    state_t          r_state    [CH];
    logic [W-1:0]    r_ref      [CH];
    logic [CW-1:0]   r_cnt      [CH];
    logic [CH-1:0]   r_steady;
    logic [CH-1:0]   r_viol;
    logic            r_busy;

    state_t          w_state_nx [CH];
    logic [W-1:0]    w_ref_nx   [CH];
    logic [CW-1:0]   w_cnt_nx   [CH];
    logic [CH-1:0]   w_steady_nx;
    logic [CH-1:0]   w_viol_nx;
    logic            w_busy_nx;

    always_comb begin
        w_steady_nx = r_steady;
        w_viol_nx   = '0;
        w_busy_nx   = 1'b0;
        for (int c = 0; c < CH; c++) begin
            w_state_nx[c] = r_state[c];
            w_ref_nx[c]   = r_ref[c];
            w_cnt_nx[c]   = r_cnt[c];
            unique case (r_state[c])
                S_IDLE: begin
                    if (foo[c]) begin
                        w_ref_nx[c]   = bar[c*W +: W];
                        w_cnt_nx[c]   = '0;
                        w_state_nx[c] = S_CHECK;
                    end
                end
                S_CHECK: begin
                    // A restart strobe takes precedence over a mismatch on the same edge
                    if (foo[c]) begin
                        w_ref_nx[c] = bar[c*W +: W];
                        w_cnt_nx[c] = '0;
                    end else if (bar[c*W +: W] != r_ref[c]) begin
                        w_viol_nx[c]  = 1'b1;
                        w_state_nx[c] = S_IDLE;
                    end else if (r_cnt[c] == HOLD_M1) begin
                        w_steady_nx[c] = 1'b1;
                        w_state_nx[c]  = S_DONE;
                    end else begin
                        w_cnt_nx[c] = r_cnt[c] + CW'(1);
                    end
                end
                S_DONE: begin
                    if (foo[c]) begin
                        w_steady_nx[c] = 1'b0;
                        w_ref_nx[c]    = bar[c*W +: W];
                        w_cnt_nx[c]    = '0;
                        w_state_nx[c]  = S_CHECK;
                    end
                end
                default: begin
                    w_state_nx[c]  = S_IDLE;
                    w_cnt_nx[c]    = '0;
                    w_steady_nx[c] = 1'b0;
                end
            endcase
            if (w_state_nx[c] == S_CHECK) begin
                w_busy_nx = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                r_state[c] <= S_IDLE;
                r_ref[c]   <= '0;
                r_cnt[c]   <= '0;
            end
            r_steady <= '0;
            r_viol   <= '0;
            r_busy   <= 1'b0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                r_state[c] <= w_state_nx[c];
                r_ref[c]   <= w_ref_nx[c];
                r_cnt[c]   <= w_cnt_nx[c];
            end
            r_steady <= w_steady_nx;
            r_viol   <= w_viol_nx;
            r_busy   <= w_busy_nx;
        end
    end

    assign bar_steady = r_steady;
    assign bar_viol   = r_viol;
    assign busy       = r_busy;

endmodule

// File: tb/tb_bar_steady_mon_mc.sv
// Bench for bar_steady_mon_mc: a 4x8 HOLD=4 instance and a 1x1 HOLD=1 instance,
// checked cycle by cycle against a behavioural model through an expectation queue.
module tb_bar_steady_mon_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  foo_a = '0;
    logic [31:0] bar_a = '0;
    logic [3:0]  steady_a, viol_a;
    logic        busy_a;
    logic [0:0]  foo_b = '0;
    logic [0:0]  bar_b = '0;
    logic [0:0]  steady_b, viol_b;
    logic        busy_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected outputs: {steady_a[3:0], viol_a[3:0], busy_a, steady_b, viol_b, busy_b}
    logic [11:0] exp_q [$];

    int         m_st     [2][4];
    logic [7:0] m_ref    [2][4];
    int         m_cnt    [2][4];
    logic       m_steady [2][4];
    logic       m_viol   [2][4];

    always #5 clk = ~clk;

    bar_steady_mon_mc #(.CH(4), .W(8), .HOLD(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .foo(foo_a), .bar(bar_a),
        .bar_steady(steady_a), .bar_viol(viol_a), .busy(busy_a)
    );

    bar_steady_mon_mc #(.CH(1), .W(1), .HOLD(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .foo(foo_b), .bar(bar_b),
        .bar_steady(steady_b), .bar_viol(viol_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 4; c++) begin
                m_st[d][c] = 0; m_ref[d][c] = '0; m_cnt[d][c] = 0;
                m_steady[d][c] = 1'b0; m_viol[d][c] = 1'b0;
            end
    endfunction

    // States: 0 idle, 1 checking, 2 done
    function automatic void model_edge(int d, int nch, int hold, int w,
                                       logic [3:0] f, logic [31:0] b);
        logic [31:0] sh;
        logic [7:0]  bc;
        for (int c = 0; c < nch; c++) begin
            sh = b >> (c * w);
            bc = (w == 8) ? sh[7:0] : {7'b0, sh[0]};
            m_viol[d][c] = 1'b0;
            if (m_st[d][c] == 0) begin
                if (f[c]) begin m_ref[d][c] = bc; m_cnt[d][c] = 0; m_st[d][c] = 1; end
            end else if (m_st[d][c] == 1) begin
                if (f[c]) begin
                    m_ref[d][c] = bc; m_cnt[d][c] = 0;
                end else if (bc != m_ref[d][c]) begin
                    m_viol[d][c] = 1'b1; m_st[d][c] = 0;
                end else if (m_cnt[d][c] + 1 == hold) begin
                    m_steady[d][c] = 1'b1; m_st[d][c] = 2;
                end else begin
                    m_cnt[d][c]++;
                end
            end else begin
                if (f[c]) begin
                    m_steady[d][c] = 1'b0; m_ref[d][c] = bc; m_cnt[d][c] = 0; m_st[d][c] = 1;
                end
            end
        end
    endfunction

    // Drive one cycle of stimulus, queue the model's prediction, compare after the edge
    task automatic step(input logic [3:0] fa, input logic [31:0] ba,
                        input logic fb, input logic bb);
        logic [11:0] e;
        foo_a = fa; bar_a = ba; foo_b[0] = fb; bar_b[0] = bb;
        model_edge(0, 4, 4, 8, fa, ba);
        model_edge(1, 1, 1, 1, {3'b0, fb}, {31'b0, bb});
        e = '0;
        for (int c = 0; c < 4; c++) begin
            e[8 + c] = m_steady[0][c];
            e[4 + c] = m_viol[0][c];
            if (m_st[0][c] == 1) e[3] = 1'b1;
        end
        e[2] = m_steady[1][0];
        e[1] = m_viol[1][0];
        e[0] = (m_st[1][0] == 1);
        exp_q.push_back(e);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        chk("steady_a", {28'b0, steady_a}, {28'b0, e[11:8]});
        chk("viol_a",   {28'b0, viol_a},   {28'b0, e[7:4]});
        chk("busy_a",   {31'b0, busy_a},   {31'b0, e[3]});
        chk("steady_b", {31'b0, steady_b}, {31'b0, e[2]});
        chk("viol_b",   {31'b0, viol_b},   {31'b0, e[1]});
        chk("busy_b",   {31'b0, busy_b},   {31'b0, e[0]});
    endtask

    // Asserts reset mid-cycle; outputs must clear without waiting for a clock edge
    task automatic apply_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, "_steady_a"}, {28'b0, steady_a}, 32'h0);
        chk({tag, "_viol_a"},   {28'b0, viol_a},   32'h0);
        chk({tag, "_busy_a"},   {31'b0, busy_a},   32'h0);
        chk({tag, "_steady_b"}, {31'b0, steady_b}, 32'h0);
        chk({tag, "_busy_b"},   {31'b0, busy_b},   32'h0);
        model_reset();
        foo_a = '0; foo_b = '0;
        @(posedge clk); #1;
        chk({tag, "_hold_viol_a"}, {28'b0, viol_a}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rb;
        logic [3:0]  rf;
        logic        rbb;
        model_reset();
        @(posedge clk); #1;
        apply_reset("rst0");

        // Stable pass on ch0
        step(4'b0001, 32'hA5, 1'b0, 1'b0);
        repeat (3) step(4'b0000, 32'hA5, 1'b0, 1'b0);
        chk("t1_not_yet", {28'b0, steady_a}, 32'h0);
        step(4'b0000, 32'hA5, 1'b0, 1'b0);
        chk("t1_steady", {31'b0, steady_a[0]}, 32'h1);
        chk("t1_busy",   {31'b0, busy_a},      32'h0);

        // Violation at the second compare edge
        step(4'b0001, 32'h3C, 1'b0, 1'b0);
        step(4'b0000, 32'h3C, 1'b0, 1'b0);
        step(4'b0000, 32'h3D, 1'b0, 1'b0);
        chk("t2_viol",   {31'b0, viol_a[0]},   32'h1);
        chk("t2_steady", {31'b0, steady_a[0]}, 32'h0);
        step(4'b0000, 32'h3D, 1'b0, 1'b0);
        chk("t2_viol_one", {31'b0, viol_a[0]}, 32'h0);

        // Restart on the same edge as a change
        step(4'b0001, 32'h3C, 1'b0, 1'b0);
        step(4'b0000, 32'h3C, 1'b0, 1'b0);
        step(4'b0001, 32'h11, 1'b0, 1'b0);
        chk("t3_no_viol", {31'b0, viol_a[0]}, 32'h0);
        repeat (3) step(4'b0000, 32'h11, 1'b0, 1'b0);
        chk("t3_early", {31'b0, steady_a[0]}, 32'h0);
        step(4'b0000, 32'h11, 1'b0, 1'b0);
        chk("t3_steady", {31'b0, steady_a[0]}, 32'h1);

        // Async reset in the middle of a check window, then re-arm
        step(4'b0001, 32'h22, 1'b0, 1'b0);
        step(4'b0000, 32'h22, 1'b0, 1'b0);
        step(4'b0000, 32'h22, 1'b0, 1'b0);
        apply_reset("t5");
        step(4'b0001, 32'h22, 1'b0, 1'b0);
        repeat (4) step(4'b0000, 32'h22, 1'b0, 1'b0);
        chk("t5_rearm", {31'b0, steady_a[0]}, 32'h1);

        // Channel independence from a clean state
        apply_reset("t4");
        step(4'b0110, 32'h0077_5500, 1'b0, 1'b0);
        step(4'b0000, 32'h0077_5500, 1'b0, 1'b0);
        step(4'b0000, 32'h0078_5500, 1'b0, 1'b0);
        chk("t4_viol", {28'b0, viol_a}, 32'h4);
        step(4'b0000, 32'h0078_5500, 1'b0, 1'b0);
        step(4'b0000, 32'h0078_5500, 1'b0, 1'b0);
        chk("t4_steady", {28'b0, steady_a}, 32'h2);
        chk("t4_viol0",  {28'b0, viol_a},   32'h0);

        // HOLD=1, W=1 instance
        step(4'b0000, 32'h0, 1'b1, 1'b1);
        step(4'b0000, 32'h0, 1'b0, 1'b1);
        chk("t6_steady", {31'b0, steady_b}, 32'h1);
        step(4'b0000, 32'h0, 1'b0, 1'b0);
        chk("t6_ignore", {31'b0, steady_b}, 32'h1);
        chk("t6_noviol", {31'b0, viol_b},   32'h0);
        step(4'b0000, 32'h0, 1'b1, 1'b0);
        chk("t6_clear", {31'b0, steady_b}, 32'h0);
        step(4'b0000, 32'h0, 1'b0, 1'b0);
        chk("t6_again", {31'b0, steady_b}, 32'h1);

        // Random traffic on both instances
        rb = 32'h0; rbb = 1'b0;
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < 4; c++) begin
                rf[c] = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 5) == 0) rb[c*8 +: 8] = 8'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 3) == 0) rbb = ~rbb;
            step(rf, rb, ($urandom_range(0, 3) == 0), rbb);
        end

        chk("queue_empty", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
